// File: rtl/seven_segment_scanner.sv
// Multi-digit hex display scanner: one shared segment bus, one-hot digit enables, frame-synchronous updates.
// Optional leading-zero blanking when LEADING_ZERO_BLANK_EN is defined.
module seven_segment_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              segments,
  output logic                    dp_out,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [CNT_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic                    pending;
  logic [3:0]              nibble;
  logic [NUM_DIGITS-1:0]   onehot;
  logic                    dp_cur;
  logic [6:0]              seg_raw;

  // Active-high segment pattern {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0:    hex_decode = 7'b0111111;
      4'h1:    hex_decode = 7'b0000110;
      4'h2:    hex_decode = 7'b1011011;
      4'h3:    hex_decode = 7'b1001111;
      4'h4:    hex_decode = 7'b1100110;
      4'h5:    hex_decode = 7'b1101101;
      4'h6:    hex_decode = 7'b1111101;
      4'h7:    hex_decode = 7'b0000111;
      4'h8:    hex_decode = 7'b1111111;
      4'h9:    hex_decode = 7'b1101111;
      4'hA:    hex_decode = 7'b1110111;
      4'hB:    hex_decode = 7'b1111100;
      4'hC:    hex_decode = 7'b0111001;
      4'hD:    hex_decode = 7'b1011110;
      4'hE:    hex_decode = 7'b1111001;
      default: hex_decode = 7'b1110001;
    endcase
  endfunction

  assign frame_done = (div_cnt == CNT_LAST) && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
    end else begin
      if (div_cnt == CNT_LAST) begin
        div_cnt <= '0;
        idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_ONE;
      end else begin
        div_cnt <= div_cnt + CNT_ONE;
      end

      if (load) begin
        shadow_val <= value_in;
        shadow_dp  <= dp_in;
      end

      // A load landing on the frame boundary bypasses the shadow so it is not delayed a whole frame
      if (load && frame_done) begin
        disp_val <= value_in;
        disp_dp  <= dp_in;
        pending  <= 1'b0;
      end else if (frame_done && pending) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
        pending  <= 1'b0;
      end else if (load) begin
        pending  <= 1'b1;
      end
    end
  end

  always_comb begin
    nibble = '0;
    onehot = '0;
    dp_cur = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nibble    = disp_val[4*i +: 4];
        onehot[i] = 1'b1;
        dp_cur    = disp_dp[i];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank;
  logic                  blank_cur;

  // Digit i blanks when it and every more significant nibble are zero; digit 0 always shows
  always_comb begin
    logic upper_zero;
    blank      = '0;
    blank_cur  = 1'b0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero && (disp_val[4*i +: 4] == 4'h0);
      blank[i]   = upper_zero;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) blank_cur = blank[i];
    end
    seg_raw = blank_cur ? 7'b0000000 : hex_decode(nibble);
  end
`else
  always_comb begin
    seg_raw = hex_decode(nibble);
  end
`endif

  assign digit_en = ACTIVE_LOW ? ~onehot : onehot;
  assign segments = ACTIVE_LOW ? ~seg_raw : seg_raw;
  assign dp_out   = dp_cur;

endmodule
